// File: rtl/luma_stat_pkg.sv
// Shared definitions for the frame luma statistics block.
//   COEF_R/G/B   : BT.601-style luma weights scaled by 256 (they sum to 256)
//   luma_state_e : frame FSM states
//   luma_stat_t  : published per-frame statistics record
//   luma_of()    : Y = (77*R + 150*G + 29*B) >> 8
package luma_stat_pkg;

  localparam logic [7:0] COEF_R = 8'd77;
  localparam logic [7:0] COEF_G = 8'd150;
  localparam logic [7:0] COEF_B = 8'd29;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DIV
  } luma_state_e;

  typedef struct packed {
    logic [7:0] avg;
    logic [7:0] min;
    logic [7:0] max;
  } luma_stat_t;

  function automatic logic [7:0] luma_of(input logic [7:0] r, input logic [7:0] g,
                                         input logic [7:0] b);
    logic [15:0] acc;
    acc = 16'(COEF_R) * 16'(r) + 16'(COEF_G) * 16'(g) + 16'(COEF_B) * 16'(b);
    return 8'(acc >> 8);
  endfunction

endpackage

// File: rtl/hdmi_unpack.sv
// Splits an HDMI pack into its fields.
// Pack layout, MSB first: {pclk, hsync, vsync, de, r[7:0], g[7:0], b[7:0], hcnt, vcnt}
//   i_pack : packed bus, PACK_SIZE bits
//   pclk   : pixel clock bit carried in the pack
//   hsync, vsync, de : timing strobes
//   r, g, b          : 8-bit colour components
//   hcnt, vcnt       : active-area pixel / line position
module hdmi_unpack #(
  parameter int unsigned  H_ACT     = 1280,
  parameter int unsigned  V_ACT     = 720,
  localparam int unsigned HW        = $clog2(H_ACT),
  localparam int unsigned VW        = $clog2(V_ACT),
  localparam int unsigned PACK_SIZE = 3 * 8 + 4 + HW + VW
) (
  input  logic [PACK_SIZE-1:0] i_pack,
  output logic                 pclk,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic [7:0]           r,
  output logic [7:0]           g,
  output logic [7:0]           b,
  output logic [HW-1:0]        hcnt,
  output logic [VW-1:0]        vcnt
);

  assign {pclk, hsync, vsync, de, r, g, b, hcnt, vcnt} = i_pack;

endmodule

// File: rtl/luma_div.sv
// Restoring divider, one quotient bit per cycle, SUM_W cycles per division.
//   clk, rstn : clock, asynchronous active-low reset
//   start     : latch dividend/divisor and begin (takes priority over abort)
//   abort     : drop the division in progress
//   dividend  : SUM_W-bit numerator
//   divisor   : CNT_W-bit denominator; zero yields quotient 0
//   busy      : division in progress
//   done      : high during the last iteration cycle; quotient is valid then
//   quotient  : SUM_W-bit result, meaningful only while done is high
module luma_div #(
  parameter int unsigned SUM_W = 15,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] quotient
);

  localparam int unsigned       STEP_W    = $clog2(SUM_W);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SUM_W - 1);

  logic              busy_q;
  logic              zero_q;
  logic [STEP_W-1:0] step_q;
  logic [CNT_W-1:0]  den_q;
  logic [CNT_W-1:0]  rem_q;
  // Dividend bits shift out of the top while quotient bits shift in at the bottom.
  logic [SUM_W-1:0]  quo_q;

  logic [CNT_W:0]    rem_shift;
  logic              fits;
  logic [CNT_W-1:0]  rem_next;
  logic [SUM_W-1:0]  quo_next;

  always_comb begin
    rem_shift = {rem_q, quo_q[SUM_W-1]};
    fits      = rem_shift >= {1'b0, den_q};
    // Remainder stays below the divisor, so it always fits back into CNT_W bits.
    rem_next  = fits ? CNT_W'(rem_shift - {1'b0, den_q}) : rem_shift[CNT_W-1:0];
    quo_next  = {quo_q[SUM_W-2:0], fits};
  end

  assign busy     = busy_q;
  assign done     = busy_q && (step_q == LAST_STEP) && !start && !abort;
  assign quotient = zero_q ? '0 : quo_next;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q <= 1'b0;
      zero_q <= 1'b0;
      step_q <= '0;
      den_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      zero_q <= (divisor == '0);
      step_q <= '0;
      den_q  <= divisor;
      rem_q  <= '0;
      quo_q  <= dividend;
    end else if (abort) begin
      busy_q <= 1'b0;
    end else if (busy_q) begin
      rem_q  <= rem_next;
      quo_q  <= quo_next;
      step_q <= step_q + STEP_W'(1);
      if (step_q == LAST_STEP) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/frame_luma_stat.sv
// Per-frame mean luma measurement driving the gamma stage enable with hysteresis.
// Optional feature macro: LUMA_MINMAX_EN (per-frame min/max luma tracking).
//   clk        : pixel clock
//   rstn       : asynchronous active-low reset
//   i_pack     : HDMI pack tapped from the gamma stage input (sink only)
//   luma_avg   : mean luma of the last completed frame
//   luma_valid : one-cycle pulse when luma_avg updates
//   gamma_en   : gamma stage enable, set below LO_TH, cleared above HI_TH
//   drop_cnt   : aborted divisions, saturating at 255
//   luma_min   : per-frame minimum luma (0 without LUMA_MINMAX_EN)
//   luma_max   : per-frame maximum luma (0 without LUMA_MINMAX_EN)
import luma_stat_pkg::*;

module frame_luma_stat #(
  parameter int unsigned  H_ACT        = 1280,
  parameter int unsigned  V_ACT        = 720,
  parameter logic [7:0]   LO_TH        = 8'd64,
  parameter logic [7:0]   HI_TH        = 8'd160,
  parameter logic         GAMMA_EN_RST = 1'b1,
  localparam int unsigned PACK_SIZE    = 3 * 8 + 4 + $clog2(H_ACT) + $clog2(V_ACT),
  localparam int unsigned SUM_W        = 8 + $clog2(H_ACT * V_ACT),
  localparam int unsigned CNT_W        = $clog2(H_ACT * V_ACT + 1)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [PACK_SIZE-1:0] i_pack,
  output logic [7:0]           luma_avg,
  output logic                 luma_valid,
  output logic                 gamma_en,
  output logic [7:0]           drop_cnt,
  output logic [7:0]           luma_min,
  output logic [7:0]           luma_max
);

  logic                      pclk, hsync, vsync, de;
  logic [7:0]                r, g, b;
  logic [$clog2(H_ACT)-1:0]  hcnt;
  logic [$clog2(V_ACT)-1:0]  vcnt;

  hdmi_unpack #(
    .H_ACT (H_ACT),
    .V_ACT (V_ACT)
  ) u_unpack (
    .i_pack (i_pack),
    .pclk   (pclk),
    .hsync  (hsync),
    .vsync  (vsync),
    .de     (de),
    .r      (r),
    .g      (g),
    .b      (b),
    .hcnt   (hcnt),
    .vcnt   (vcnt)
  );

  logic unused_pack;
  assign unused_pack = ^{pclk, hsync, hcnt, vcnt};

  // Luma stage and vsync edge registers.
  logic [7:0] y_q;
  logic       de_q, vsync_q, vsync_qq;
  logic       boundary;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      y_q      <= '0;
      de_q     <= 1'b0;
      vsync_q  <= 1'b0;
      vsync_qq <= 1'b0;
    end else begin
      y_q      <= luma_of(r, g, b);
      de_q     <= de;
      vsync_q  <= vsync;
      vsync_qq <= vsync_q;
    end
  end

  assign boundary = vsync_q & ~vsync_qq;

  // Frame FSM.
  luma_state_e      state_q, state_d;
  logic             div_start, div_abort, div_busy, div_done;
  logic [SUM_W-1:0] quotient;

  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (boundary) state_d = ACCUM;
      end
      ACCUM: begin
        if (boundary) begin
          state_d   = DIV;
          div_start = 1'b1;
        end
      end
      DIV: begin
        // A new boundary restarts the divider on the fresh frame.
        if (boundary) div_start = 1'b1;
        else if (div_done) state_d = ACCUM;
      end
      default: state_d = IDLE;
    endcase
  end

  assign div_abort = boundary && div_busy;

  // Accumulators; the boundary-cycle pixel belongs to the new frame.
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sum_d = sum_q;
    cnt_d = cnt_q;
    if (boundary) begin
      sum_d = de_q ? SUM_W'(y_q) : '0;
      cnt_d = de_q ? CNT_W'(1) : '0;
    end else if (state_q == IDLE) begin
      sum_d = '0;
      cnt_d = '0;
    end else if (de_q) begin
      sum_d = sum_q + SUM_W'(y_q);
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  luma_div #(
    .SUM_W (SUM_W),
    .CNT_W (CNT_W)
  ) u_div (
    .clk      (clk),
    .rstn     (rstn),
    .start    (div_start),
    .abort    (div_abort),
    .dividend (sum_q),
    .divisor  (cnt_q),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quotient)
  );

  // Mean of 8-bit samples never exceeds 255.
  logic unused_quot;
  assign unused_quot = ^quotient[SUM_W-1:8];

  luma_stat_t stat_d, stat_q;

`ifdef LUMA_MINMAX_EN
  logic [7:0] min_q, min_d, max_q, max_d;
  logic [7:0] frame_min_q, frame_max_q;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (boundary) begin
      min_d = de_q ? y_q : '0;
      max_d = de_q ? y_q : '0;
    end else if (state_q == IDLE) begin
      min_d = '0;
      max_d = '0;
    end else if (de_q) begin
      // An empty count marks the first pixel of the frame.
      if (cnt_q == '0 || y_q < min_q) min_d = y_q;
      if (cnt_q == '0 || y_q > max_q) max_d = y_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      min_q       <= '0;
      max_q       <= '0;
      frame_min_q <= '0;
      frame_max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
      if (div_start) begin
        frame_min_q <= min_q;
        frame_max_q <= max_q;
      end
    end
  end

  always_comb begin
    stat_d.avg = quotient[7:0];
    stat_d.min = frame_min_q;
    stat_d.max = frame_max_q;
  end
`else
  always_comb begin
    stat_d.avg = quotient[7:0];
    stat_d.min = '0;
    stat_d.max = '0;
  end
`endif

  logic       luma_valid_q, gamma_en_q;
  logic [7:0] drop_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      sum_q        <= '0;
      cnt_q        <= '0;
      stat_q       <= '0;
      luma_valid_q <= 1'b0;
      gamma_en_q   <= GAMMA_EN_RST;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      sum_q        <= sum_d;
      cnt_q        <= cnt_d;
      luma_valid_q <= div_done;
      if (div_done) begin
        stat_q <= stat_d;
        if (stat_d.avg < LO_TH) gamma_en_q <= 1'b1;
        else if (stat_d.avg > HI_TH) gamma_en_q <= 1'b0;
      end
      if (div_abort && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
  end

  assign luma_avg   = stat_q.avg;
  assign luma_min   = stat_q.min;
  assign luma_max   = stat_q.max;
  assign luma_valid = luma_valid_q;
  assign gamma_en   = gamma_en_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_frame_luma_stat.sv
// Directed bench for frame_luma_stat with H_ACT=16, V_ACT=8 (SUM_W=15, latency 16).
module tb_frame_luma_stat;

  logic        clk = 1'b0;
  logic        rstn;
  logic        hs, vs, de;
  logic [7:0]  pr, pg, pb;
  logic [34:0] pack;
  logic [7:0]  luma_avg, drop_cnt, luma_min, luma_max;
  logic        luma_valid, gamma_en;

  int total = 0;
  int bad = 0;
  int valid_seen = 0;

`ifdef LUMA_MINMAX_EN
  localparam logic [7:0] EXP_MIN = 8'd10;
  localparam logic [7:0] EXP_MAX = 8'd200;
`else
  localparam logic [7:0] EXP_MIN = 8'd0;
  localparam logic [7:0] EXP_MAX = 8'd0;
`endif

  always #5 clk = ~clk;

  // {pclk, hsync, vsync, de, r, g, b, hcnt[3:0], vcnt[2:0]}
  assign pack = {1'b0, hs, vs, de, pr, pg, pb, 7'd0};

  frame_luma_stat #(
    .H_ACT (16),
    .V_ACT (8)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .i_pack     (pack),
    .luma_avg   (luma_avg),
    .luma_valid (luma_valid),
    .gamma_en   (gamma_en),
    .drop_cnt   (drop_cnt),
    .luma_min   (luma_min),
    .luma_max   (luma_max)
  );

  always @(negedge clk) begin
    if (rstn && luma_valid === 1'b1) valid_seen++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pixels(input logic [7:0] r0, input logic [7:0] g0, input logic [7:0] b0,
                        input int n);
    de = 1'b1;
    pr = r0;
    pg = g0;
    pb = b0;
    repeat (n) step();
    de = 1'b0;
  endtask

  task automatic gray(input logic [7:0] v, input int n);
    pixels(v, v, v, n);
  endtask

  // Leaves the bench in the boundary cycle N.
  task automatic boundary();
    de = 1'b0;
    vs = 1'b1;
    step();
    vs = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (luma_valid !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    hs = 1'b0; vs = 1'b0; de = 1'b0;
    pr = 8'd0; pg = 8'd0; pb = 8'd0;
    step();
    step();
    total++;
    if (luma_avg !== 8'd0) begin
      bad++; $display("FAIL reset_avg: got %0d want 0", luma_avg);
    end
    total++;
    if (luma_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid: got %0b want 0", luma_valid);
    end
    total++;
    if (gamma_en !== 1'b1) begin
      bad++; $display("FAIL reset_gamma: got %0b want 1", gamma_en);
    end
    total++;
    if (drop_cnt !== 8'd0) begin
      bad++; $display("FAIL reset_drop: got %0d want 0", drop_cnt);
    end
    total++;
    if ({luma_min, luma_max} !== 16'd0) begin
      bad++; $display("FAIL reset_minmax: got %0d/%0d want 0/0", luma_min, luma_max);
    end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_average();
    int lat;
    int v0;
    gray(8'd250, 5);
    boundary();
    v0 = valid_seen;
    gray(8'd100, 16);
    repeat (6) step();
    total++;
    if (valid_seen !== v0) begin
      bad++; $display("FAIL first_boundary_silent: got %0d pulses want 0", valid_seen - v0);
    end
    boundary();
    wait_valid(lat);
    total++;
    if (lat !== 16) begin
      bad++; $display("FAIL avg_latency: got %0d want 16", lat);
    end
    total++;
    if (luma_avg !== 8'd100) begin
      bad++; $display("FAIL avg_100: got %0d want 100", luma_avg);
    end
    total++;
    if (gamma_en !== 1'b1) begin
      bad++; $display("FAIL avg_gamma: got %0b want 1", gamma_en);
    end
    step();
    total++;
    if (luma_valid !== 1'b0) begin
      bad++; $display("FAIL valid_one_cycle: got %0b want 0", luma_valid);
    end
  endtask

  task automatic test_hysteresis();
    int lat;
    gray(8'd255, 16);
    boundary();
    wait_valid(lat);
    total++;
    if (luma_avg !== 8'd255) begin
      bad++; $display("FAIL white_avg: got %0d want 255", luma_avg);
    end
    total++;
    if (gamma_en !== 1'b0) begin
      bad++; $display("FAIL white_gamma: got %0b want 0", gamma_en);
    end
    gray(8'd100, 16);
    boundary();
    wait_valid(lat);
    total++;
    if (luma_avg !== 8'd100) begin
      bad++; $display("FAIL hyst_avg: got %0d want 100", luma_avg);
    end
    total++;
    if (gamma_en !== 1'b0) begin
      bad++; $display("FAIL hyst_gamma_hold: got %0b want 0", gamma_en);
    end
  endtask

  task automatic test_empty();
    int lat;
    boundary();
    wait_valid(lat);
    total++;
    if (lat !== 16) begin
      bad++; $display("FAIL empty_latency: got %0d want 16", lat);
    end
    total++;
    if (luma_avg !== 8'd0) begin
      bad++; $display("FAIL empty_avg: got %0d want 0", luma_avg);
    end
    total++;
    if (gamma_en !== 1'b1) begin
      bad++; $display("FAIL empty_gamma: got %0b want 1", gamma_en);
    end
  endtask

  task automatic test_color();
    int lat;
    // Y = 76, 149, 28 -> 253 / 3 = 84
    pixels(8'd255, 8'd0, 8'd0, 1);
    pixels(8'd0, 8'd255, 8'd0, 1);
    pixels(8'd0, 8'd0, 8'd255, 1);
    boundary();
    wait_valid(lat);
    total++;
    if (luma_avg !== 8'd84) begin
      bad++; $display("FAIL color_avg: got %0d want 84", luma_avg);
    end
    // 61 / 3 = 20 (truncated)
    gray(8'd10, 1);
    gray(8'd20, 1);
    gray(8'd31, 1);
    boundary();
    wait_valid(lat);
    total++;
    if (luma_avg !== 8'd20) begin
      bad++; $display("FAIL trunc_avg: got %0d want 20", luma_avg);
    end
  endtask

  task automatic test_minmax();
    int lat;
    gray(8'd10, 1);
    gray(8'd50, 1);
    gray(8'd200, 1);
    gray(8'd120, 1);
    boundary();
    wait_valid(lat);
    total++;
    if (luma_avg !== 8'd95) begin
      bad++; $display("FAIL minmax_avg: got %0d want 95", luma_avg);
    end
    total++;
    if (luma_min !== EXP_MIN) begin
      bad++; $display("FAIL luma_min: got %0d want %0d", luma_min, EXP_MIN);
    end
    total++;
    if (luma_max !== EXP_MAX) begin
      bad++; $display("FAIL luma_max: got %0d want %0d", luma_max, EXP_MAX);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int v0;
    gray(8'd50, 4);
    boundary();
    total++;
    if (drop_cnt !== 8'd0) begin
      bad++; $display("FAIL drop_before: got %0d want 0", drop_cnt);
    end
    v0 = valid_seen;
    gray(8'd200, 4);
    boundary();
    total++;
    if (valid_seen !== v0) begin
      bad++; $display("FAIL abort_silent: got %0d pulses want 0", valid_seen - v0);
    end
    wait_valid(lat);
    total++;
    if (lat !== 16) begin
      bad++; $display("FAIL restart_latency: got %0d want 16", lat);
    end
    total++;
    if (luma_avg !== 8'd200) begin
      bad++; $display("FAIL restart_avg: got %0d want 200", luma_avg);
    end
    total++;
    if (drop_cnt !== 8'd1) begin
      bad++; $display("FAIL drop_cnt: got %0d want 1", drop_cnt);
    end
    total++;
    if (gamma_en !== 1'b0) begin
      bad++; $display("FAIL restart_gamma: got %0b want 0", gamma_en);
    end
  endtask

  task automatic test_reset_mid_div();
    int lat;
    int v0;
    gray(8'd80, 3);
    boundary();
    repeat (5) step();
    rstn = 1'b0;
    step();
    total++;
    if (luma_avg !== 8'd0) begin
      bad++; $display("FAIL rst_mid_avg: got %0d want 0", luma_avg);
    end
    total++;
    if (gamma_en !== 1'b1) begin
      bad++; $display("FAIL rst_mid_gamma: got %0b want 1", gamma_en);
    end
    total++;
    if (drop_cnt !== 8'd0) begin
      bad++; $display("FAIL rst_mid_drop: got %0d want 0", drop_cnt);
    end
    rstn = 1'b1;
    step();
    v0 = valid_seen;
    repeat (20) step();
    gray(8'd250, 3);
    boundary();
    gray(8'd100, 8);
    repeat (20) step();
    total++;
    if (valid_seen !== v0) begin
      bad++; $display("FAIL rst_silent: got %0d pulses want 0", valid_seen - v0);
    end
    boundary();
    wait_valid(lat);
    total++;
    if (lat !== 16) begin
      bad++; $display("FAIL rst_latency: got %0d want 16", lat);
    end
    total++;
    if (luma_avg !== 8'd100) begin
      bad++; $display("FAIL rst_avg: got %0d want 100", luma_avg);
    end
  endtask

  initial begin
    test_reset();
    test_average();
    test_hysteresis();
    test_empty();
    test_color();
    test_minmax();
    test_back_to_back();
    test_reset_mid_div();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
